// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the counter/timer group.
// Functions operate at WIDTH_MAX; callers zero-extend and truncate to their width.
package gray_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros from zero-extension leave the prefix XOR unaffected.
  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] gray);
    logic [WIDTH_MAX-1:0] bin;
    bin[WIDTH_MAX-1] = gray[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared with pointer comparators.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  assign binary = WIDTH'(gray2bin(WIDTH_MAX'(gray)));

endmodule

// File: rtl/gray_counter_n.sv
// Width-generic up/down Gray counter with load, overflow/underflow flags and a wrap pulse.
// Output is registered straight from the next binary state so it never glitches.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter bit          STICKY = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gray_counter_n: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  localparam logic [WIDTH-1:0] MaxVal = '1;

  logic [WIDTH-1:0] b_q, b_d, gray_q, gray_d, load_bin;
  logic             ovf_q, ovf_d, udf_q, udf_d, wrap_q, wrap_d;
  logic             up_wrap, down_wrap;

  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_conv (
    .gray  (LoadValue),
    .binary(load_bin)
  );

  always_comb begin
    b_d       = b_q;
    up_wrap   = 1'b0;
    down_wrap = 1'b0;
    if (Load) begin
      b_d = load_bin;
    end else if (En) begin
      if (!Dir) begin
        up_wrap = (b_q == MaxVal);
        b_d     = b_q + 1'b1;
      end else begin
        down_wrap = (b_q == '0);
        b_d       = b_q - 1'b1;
      end
    end
    wrap_d = up_wrap | down_wrap;

    // A wrap on the same edge as ClrFlags leaves its flag set.
    if (STICKY) begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (ClrFlags) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (up_wrap)   ovf_d = 1'b1;
      if (down_wrap) udf_d = 1'b1;
    end else begin
      ovf_d = up_wrap;
      udf_d = down_wrap;
    end

    gray_d = WIDTH'(bin2gray(WIDTH_MAX'(b_d)));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      b_q    <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      wrap_q <= wrap_d;
    end
  end

  assign Output    = gray_q;
  assign Binary    = b_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;
  assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: four instances (3/4/8-bit sticky, 8-bit non-sticky) on shared stimulus.
module tb_gray_counter_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, load = 1'b0, clr = 1'b0;
  logic [7:0] lv = '0;

  logic [2:0] out3, bin3;
  logic [3:0] out4, bin4;
  logic [7:0] out8, bin8, out8n, bin8n;
  logic       ov3, un3, wr3, ov4, un4, wr4, ov8, un8, wr8, ov8n, un8n, wr8n;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(3), .STICKY(1'b1)) d3 (
    .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load), .LoadValue(lv[2:0]),
    .ClrFlags(clr), .Output(out3), .Binary(bin3), .Overflow(ov3), .Underflow(un3), .Wrap(wr3)
  );
  gray_counter_n #(.WIDTH(4), .STICKY(1'b1)) d4 (
    .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load), .LoadValue(lv[3:0]),
    .ClrFlags(clr), .Output(out4), .Binary(bin4), .Overflow(ov4), .Underflow(un4), .Wrap(wr4)
  );
  gray_counter_n #(.WIDTH(8), .STICKY(1'b1)) d8 (
    .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load), .LoadValue(lv),
    .ClrFlags(clr), .Output(out8), .Binary(bin8), .Overflow(ov8), .Underflow(un8), .Wrap(wr8)
  );
  gray_counter_n #(.WIDTH(8), .STICKY(1'b0)) d8n (
    .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load), .LoadValue(lv),
    .ClrFlags(clr), .Output(out8n), .Binary(bin8n), .Overflow(ov8n), .Underflow(un8n),
    .Wrap(wr8n)
  );

  logic [7:0] dout[4], dbin[4];
  logic       dov[4], dun[4], dwr[4];
  assign dout[0] = 8'(out3);
  assign dout[1] = 8'(out4);
  assign dout[2] = out8;
  assign dout[3] = out8n;
  assign dbin[0] = 8'(bin3);
  assign dbin[1] = 8'(bin4);
  assign dbin[2] = bin8;
  assign dbin[3] = bin8n;
  assign dov[0] = ov3;
  assign dov[1] = ov4;
  assign dov[2] = ov8;
  assign dov[3] = ov8n;
  assign dun[0] = un3;
  assign dun[1] = un4;
  assign dun[2] = un8;
  assign dun[3] = un8n;
  assign dwr[0] = wr3;
  assign dwr[1] = wr4;
  assign dwr[2] = wr8;
  assign dwr[3] = wr8n;

  int nchk = 0, nerr = 0;
  int mw[4], mst[4];
  int mb[4], mov[4], mun[4], mwr[4];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  // Find the count whose Gray code is g, by search over the code space.
  function automatic int bin_of_gray(input int g, input int w);
    for (int n = 0; n < (1 << w); n++) begin
      if (gray_of(n) == g) return n;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      mb[k] = 0; mov[k] = 0; mun[k] = 0; mwr[k] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 4; k++) begin
      int modulus = 1 << mw[k];
      int upw = 0, dnw = 0;
      if (load) begin
        mb[k] = bin_of_gray(int'(lv) % modulus, mw[k]);
      end else if (en && !dir) begin
        if (mb[k] == modulus - 1) upw = 1;
        mb[k] = (mb[k] + 1) % modulus;
      end else if (en && dir) begin
        if (mb[k] == 0) dnw = 1;
        mb[k] = (mb[k] + modulus - 1) % modulus;
      end
      mwr[k] = upw | dnw;
      if (mst[k] != 0) begin
        if (clr) begin mov[k] = 0; mun[k] = 0; end
        if (upw != 0) mov[k] = 1;
        if (dnw != 0) mun[k] = 1;
      end else begin
        mov[k] = upw;
        mun[k] = dnw;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s[%0d].Output", tag, k), int'(dout[k]), gray_of(mb[k]));
      chk($sformatf("%s[%0d].Binary", tag, k), int'(dbin[k]), mb[k]);
      chk($sformatf("%s[%0d].Overflow", tag, k), int'(dov[k]), mov[k]);
      chk($sformatf("%s[%0d].Underflow", tag, k), int'(dun[k]), mun[k]);
      chk($sformatf("%s[%0d].Wrap", tag, k), int'(dwr[k]), mwr[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 0; dir = 0; load = 0; clr = 0; lv = '0;
    #3;
    model_reset();
    check_all("reset_low");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic       dir;
    logic [2:0] exp_out;
    logic       exp_wrap;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[9];
  logic [7:0] prev[4];

  initial begin
    mw  = '{3, 4, 8, 8};
    mst = '{1, 1, 1, 0};

    // 3-bit up count from reset through the wrap.
    tbl[0] = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 3'b011, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3'b010, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'b110, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'b111, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 3'b101, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b1};

    do_reset();
    check_all("after_reset");
    chk("reset.out3", int'(out3), 0);
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en;
      dir = tbl[i].dir;
      tick();
      chk($sformatf("up3[%0d].Output", i), int'(out3), int'(tbl[i].exp_out));
      chk($sformatf("up3[%0d].Wrap", i), int'(wr3), int'(tbl[i].exp_wrap));
      chk($sformatf("up3[%0d].Overflow", i), int'(ov3), int'(tbl[i].exp_ovf));
      check_all("up3");
    end

    // Down from reset: immediate underflow to max.
    do_reset();
    en = 1; dir = 1;
    tick();
    chk("down.out3", int'(out3), 3'b100);
    chk("down.bin3", int'(bin3), 7);
    chk("down.wrap3", int'(wr3), 1);
    chk("down.udf3", int'(un3), 1);
    tick();
    chk("down2.out3", int'(out3), 3'b101);
    chk("down2.wrap3", int'(wr3), 0);
    check_all("down");

    // Load beats En; next up-count continues from the loaded value.
    do_reset();
    en = 1; dir = 0; load = 1; lv = 8'b0000_1100;
    tick();
    chk("load.out4", int'(out4), 4'b1100);
    chk("load.bin4", int'(bin4), 8);
    chk("load.wrap4", int'(wr4), 0);
    load = 0;
    tick();
    chk("load_next.out4", int'(out4), 4'b1101);
    check_all("load");

    // ClrFlags on the wrapping edge loses to the wrap; alone it clears.
    do_reset();
    en = 1; dir = 0;
    repeat (7) tick();
    clr = 1;
    tick();
    chk("clrwrap.ovf3", int'(ov3), 1);
    chk("clrwrap.wrap3", int'(wr3), 1);
    en = 0;
    tick();
    chk("clr.ovf3", int'(ov3), 0);
    chk("clr.udf3", int'(un3), 0);
    clr = 0;
    check_all("clr");

    // Asynchronous reset between edges at Output=0110 (4-bit).
    do_reset();
    en = 1; dir = 0;
    repeat (4) tick();
    chk("mid.out4", int'(out4), 4'b0110);
    #1 rst_n = 1'b0;
    #1;
    chk("async.out4", int'(out4), 0);
    chk("async.bin4", int'(bin4), 0);
    model_reset();
    check_all("async");
    rst_n = 1'b1;
    tick();
    chk("resume.out4", int'(out4), 4'b0001);
    check_all("resume");

    // Random traffic against the model, plus single-bit-step checks.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      en   = ($urandom % 4) != 0;
      dir  = $urandom % 2;
      load = ($urandom % 16) == 0;
      clr  = ($urandom % 8) == 0;
      lv   = 8'($urandom);
      for (int k = 0; k < 4; k++) prev[k] = dout[k];
      tick();
      check_all("rand");
      if (!load) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("rand[%0d].onebit", k), int'($countones(dout[k] ^ prev[k]) <= 1), 1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter that generalises the fixed 3-bit Gray counter to any width. It adds up/down counting, synchronous load, separate sticky overflow/underflow flags with a clear input, and a one-cycle wrap pulse. It sits in the counter/timer group and feeds Gray-coded values to pointer-comparison and cross-domain logic that needs single-bit-change sequences.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- STICKY, 1: 1 = Overflow/Underflow hold until cleared; 0 = they mirror the Wrap pulse.

- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; all state is cleared while low.
- En  in  1  count enable; sampled on the rising edge of Clk.
- Dir  in  1  0 = count up, 1 = count down.
- Load  in  1  synchronous load strobe.
- LoadValue  in  WIDTH  Gray-coded value to load.
- ClrFlags  in  1  synchronous clear of Overflow and Underflow.
- Output  out  WIDTH  current count, Gray-coded.
- Binary  out  WIDTH  current count, binary equivalent of Output.
- Overflow  out  1  up-count wrapped from max to 0.
- Underflow  out  1  down-count wrapped from 0 to max.
- Wrap  out  1  one-cycle pulse on any wrap in either direction.

## Operation
- State: binary count register B (WIDTH bits), Overflow reg, Underflow reg, Wrap reg.
- Output is registered as bin2gray(B) = B ^ (B >> 1), so Output is glitch-free; Binary = B.
- Each rising edge of Clk, evaluate in this priority order:
  - Load=1: B <= gray2bin(LoadValue). Wrap stays 0. En and Dir are ignored. Flags are unchanged except by ClrFlags.
  - Else if En=1 and Dir=0: B <= B+1 modulo 2^WIDTH. When B = 2^WIDTH-1, set Wrap=1 and Overflow=1.
  - Else if En=1 and Dir=1: B <= B-1 modulo 2^WIDTH. When B = 0, set Wrap=1 and Underflow=1.
  - Else: hold.
- Wrap is 0 on every cycle without a wrap event.
- ClrFlags=1 clears both flags in the same edge. A wrap event in that same cycle wins: the corresponding flag ends at 1.
- STICKY=0: Overflow and Underflow equal the Wrap pulse qualified by direction. ClrFlags has no effect.
- Consecutive Output values always differ in exactly one bit, in both directions and across the wrap. A load may change any number of bits.
- A direction change takes effect on the next counting edge. There are no extra states.

## Timing
- Reset low, asynchronous: B=0, Output=0, Binary=0, Overflow=0, Underflow=0, Wrap=0. These values hold while Reset is low.
- Reset release: the first count happens on the first rising edge of Clk that samples En=1 with Reset high.
- Latency: one cycle from sampled En/Load/ClrFlags to the updated outputs. All outputs are registered.
- Wrap asserts in the same cycle that Output shows the wrapped value:
  - 0 after an up-wrap.
  - gray(2^WIDTH-1) = 1 followed by zeros after a down-wrap.
- Reset asserted mid-count: outputs clear immediately, and any pending Wrap is discarded.
- Load with a non-Gray-aligned value is impossible, because every WIDTH-bit pattern is a valid Gray code.

## Structure
- Shared package gray_pkg:
  - function bin2gray(WIDTH-generic).
  - function gray2bin(WIDTH-generic, XOR prefix from the MSB).
  - localparams for WIDTH_MIN=2 and WIDTH_MAX=16.
- One sub-module: gray2bin_conv, a combinational converter for LoadValue. It is reused by pointer comparators elsewhere.
- Elaboration-time check: WIDTH must be within WIDTH_MIN..WIDTH_MAX.

## Test plan
- WIDTH=3, En=1, Dir=0 for 9 edges from reset:
  - Output sequence 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - Wrap pulses exactly at the final 000, and Overflow=1 thereafter.
- WIDTH=3, Dir=1 from reset:
  - First edge: Output=100, Binary=7, Wrap=1, Underflow=1.
  - Next edge: Output=101, Wrap=0.
- Load=1, LoadValue=4'b1100 with En=1 in the same cycle (WIDTH=4):
  - Output=1100 and Binary=8; no count occurs.
  - Next up-count gives Output=1101.
- ClrFlags=1 on the same edge as an up-wrap (STICKY=1): Overflow remains 1. ClrFlags alone on the next edge: Overflow=0, Underflow=0.
- Reset pulled low asynchronously between edges while mid-count at Output=0110: all outputs are 0 before the next Clk edge, and counting resumes from 0001.
- Random En/Dir/Load for 10k cycles, WIDTH=8, checked against a reference model:
  - Outputs match the model.
  - Output has Hamming distance ≤1 between consecutive values on non-load cycles.
